// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-register constants and occupancy state enum
//
// Purpose: definitions common to the IF/ID, ID/EX and EX/MEM stage registers.
//   NOP_INSTR_RV32 : RV32 canonical NOP (addi x0,x0,0)
//   stage_state_t  : stage occupancy {EMPTY, FULL, SKID}
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR_RV32 = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // main register invalid
        FULL  = 2'd1,   // main valid, skid entry empty
        SKID  = 2'd2    // main and skid entry both valid
    } stage_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic data-width skid entry for pipeline registers
//
// Purpose: holds one overflow beat while the downstream stage stalls.
//   Validity is tracked by the owning stage's state machine, so this module
//   holds data only.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_load  : capture i_data at the next edge
//   i_data  : beat to capture
//   o_data  : captured beat
module pipe_skid_buf #(
    parameter int W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/if_id_stage_reg.sv
// rtl/if_id_stage_reg.sv - IF/ID pipeline register with valid/ready handshake and flush bubble
//
// Purpose: carries PC and instruction from fetch to decode. A decode stall
//   backpressures fetch without losing an instruction; flush inserts a NOP
//   bubble and keeps the flush-cycle PC on pc_out for trace.
// Configuration macro: IF_ID_SKID_EN
//   defined   : 2-entry (main + skid) buffer, registered in_ready
//   undefined : single register, in_ready = !out_valid || out_ready
// Ports:
//   clk, rst                 : clock (rising edge), synchronous active-high reset
//   flush                    : discard held and incoming instructions this cycle
//   in_valid/in_ready        : fetch-side handshake
//   pc_in, instruction_in    : fetch-side payload
//   out_valid/out_ready      : decode-side handshake
//   pc_out, instruction_out  : decode-side payload (NOP when out_valid=0)
//   bubble                   : current output is a flush-generated NOP
module if_id_stage_reg
    import pipe_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter int          INSTR_W   = 32,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_RV32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instruction_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               bubble
);

    localparam logic [INSTR_W-1:0] L_NOP = INSTR_W'(NOP_INSTR);

    stage_state_t       r_state;
    stage_state_t       w_next_state;
    logic               r_out_valid;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_bubble;

    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main;

    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    // Main takes new input only when it is free or being drained this cycle.
    assign w_load_main = w_in_fire && ((r_state == EMPTY) || w_out_fire);

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) w_next_state = FULL;
                // Without the skid entry an input in FULL implies out_ready,
                // so the SKID branch is unreachable in that build.
                FULL: begin
                    if (w_in_fire && !w_out_fire)      w_next_state = SKID;
                    else if (!w_in_fire && w_out_fire) w_next_state = EMPTY;
                end
                SKID:    if (w_out_fire) w_next_state = FULL;
                default: w_next_state = EMPTY;
            endcase
        end
    end

`ifdef IF_ID_SKID_EN
    logic                       r_in_ready;
    logic                       w_skid_load;
    logic                       w_load_from_skid;
    logic [PC_W+INSTR_W-1:0]    w_skid_data;

    assign w_skid_load      = w_in_fire && (r_state == FULL) && !out_ready;
    assign w_load_from_skid = (r_state == SKID) && w_out_fire;
    assign w_in_ready       = r_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_next_state != SKID);
        end
    end

    pipe_skid_buf #(
        .W (PC_W + INSTR_W)
    ) u_skid (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_load (w_skid_load),
        .i_data ({pc_in, instruction_in}),
        .o_data (w_skid_data)
    );
`else
    assign w_in_ready = !r_out_valid || out_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_instr     <= L_NOP;
            r_bubble    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state != EMPTY);
            if (flush) begin
                // Flush-cycle PC is kept for debug/trace; input is dropped.
                r_pc     <= pc_in;
                r_instr  <= L_NOP;
                r_bubble <= 1'b1;
            end else begin
                if (w_in_fire) begin
                    r_bubble <= 1'b0;
                end
                if (w_load_main) begin
                    r_pc    <= pc_in;
                    r_instr <= instruction_in;
                end
`ifdef IF_ID_SKID_EN
                else if (w_load_from_skid) begin
                    {r_pc, r_instr} <= w_skid_data;
                end
`endif
                else if (w_out_fire) begin
                    // Drained to empty: show NOP, keep last PC.
                    r_instr <= L_NOP;
                end
            end
        end
    end

    assign in_ready        = w_in_ready;
    assign out_valid       = r_out_valid;
    assign pc_out          = r_pc;
    assign instruction_out = r_instr;
    assign bubble          = r_bubble;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// tb/tb_if_id_stage_reg.sv - self-checking bench for if_id_stage_reg
module tb_if_id_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, bubble;
    logic [31:0] pc_in, instruction_in, pc_out, instruction_out;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Reference model: FIFO of held instructions plus idle-PC and bubble flag.
    ent_t        q[$];
    logic [31:0] m_pc     = 32'h0;
    logic        m_bubble = 1'b0;

`ifdef IF_ID_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    if_id_stage_reg dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .pc_in           (pc_in),
        .instruction_in  (instruction_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .bubble          (bubble)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic m_in_ready();
        if (DEPTH == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic logic [65:0] m_out();
        if (q.size() > 0) return {1'b1, q[0].pc, q[0].ins, m_bubble};
        return {1'b0, m_pc, 32'h13, m_bubble};
    endfunction

    function automatic logic [65:0] obs();
        return {out_valid, pc_out, instruction_out, bubble};
    endfunction

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] p, input logic [31:0] i, input logic o);
        rst = r; flush = f; in_valid = v; pc_in = p; instruction_in = i; out_ready = o;
        #1;
    endtask

    task automatic tick();
        logic fire;
        ent_t e;
        fire = in_valid && m_in_ready();
        e.pc = pc_in;
        e.ins = instruction_in;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_pc = 32'h0;
            m_bubble = 1'b0;
        end else if (flush) begin
            q.delete();
            m_pc = e.pc;
            m_bubble = 1'b1;
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (fire) begin
                q.push_back(e);
                m_bubble = 1'b0;
            end
            if (q.size() > 0) m_pc = q[0].pc;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h55, 1'b1);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (obs() !== {1'b0, 32'h0, 32'h13, 1'b0})
            $display("FAIL reset_outputs got=%h exp=%h", obs(), {1'b0, 32'h0, 32'h13, 1'b0});
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else n_pass++;
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 32'(k * 4), 32'hA + 32'(k), 1'b1);
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got=%b exp=1", k, in_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (obs() !== {1'b1, 32'(k * 4), 32'hA + 32'(k), 1'b0})
                $display("FAIL stream_out[%0d] got=%h exp=%h", k, obs(),
                         {1'b1, 32'(k * 4), 32'hA + 32'(k), 1'b0});
            else n_pass++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || instruction_out !== 32'h13)
            $display("FAIL stream_drain got=%b/%h exp=0/00000013", out_valid, instruction_out);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hA, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h4, 32'hB, 1'b0);
        n_checks++;
        if (in_ready !== m_in_ready()) $display("FAIL bp_in_ready_pre got=%b exp=%b", in_ready, m_in_ready());
        else n_pass++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (obs() !== {1'b1, 32'h0, 32'hA, 1'b0})
            $display("FAIL bp_hold got=%h exp=%h", obs(), {1'b1, 32'h0, 32'hA, 1'b0});
        else n_pass++;
        n_checks++;
        if (in_ready !== m_in_ready()) $display("FAIL bp_in_ready_full got=%b exp=%b", in_ready, m_in_ready());
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            tick();
            n_checks++;
            if (obs() !== m_out()) $display("FAIL bp_release[%0d] got=%h exp=%h", k, obs(), m_out());
            else n_pass++;
        end
    endtask

    task automatic test_flush_skid();
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h21, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h24, 32'h25, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h41, 1'b0);
        tick();
        n_checks++;
        if (obs() !== {1'b0, 32'h40, 32'h13, 1'b1})
            $display("FAIL flush_out got=%h exp=%h", obs(), {1'b0, 32'h40, 32'h13, 1'b1});
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        n_checks++;
        if (obs() !== {1'b0, 32'h40, 32'h13, 1'b1})
            $display("FAIL flush_no_deliver got=%h exp=%h", obs(), {1'b0, 32'h40, 32'h13, 1'b1});
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 32'h50, 32'h51, 1'b0);
        tick();
        n_checks++;
        if (obs() !== {1'b1, 32'h50, 32'h51, 1'b0})
            $display("FAIL flush_bubble_clear got=%h exp=%h", obs(), {1'b1, 32'h50, 32'h51, 1'b0});
        else n_pass++;
    endtask

    task automatic test_flush_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h60, 32'h61, 1'b0);
        tick();
        n_checks++;
        if (obs() !== {1'b0, 32'h0, 32'h13, 1'b0})
            $display("FAIL flush_reset got=%h exp=%h", obs(), {1'b0, 32'h0, 32'h13, 1'b0});
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1'b0, 1'b1, 32'h8, 32'hC, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'hC, 32'hD, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL simul_in_ready got=%b exp=1", in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== {1'b1, 32'hC, 32'hD, 1'b0})
            $display("FAIL simul_out got=%h exp=%h", obs(), {1'b1, 32'hC, 32'hD, 1'b0});
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (in_ready !== m_in_ready()) $display("FAIL simul_state_full got=%b exp=%b", in_ready, m_in_ready());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0);
            n_checks++;
            if (in_ready !== m_in_ready())
                $display("FAIL rand_in_ready[%0d] got=%b exp=%b", n, in_ready, m_in_ready());
            else n_pass++;
            tick();
            n_checks++;
            if (obs() !== m_out()) $display("FAIL rand_out[%0d] got=%h exp=%h", n, obs(), m_out());
            else n_pass++;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_skid();
        test_flush_reset();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage_reg.md
# if_id_stage_reg

Parametrised IF/ID pipeline register: the successor of the plain flush-only IF/ID latch. It carries PC and instruction from fetch to decode under a valid/ready handshake, so a decode stall backpressures fetch without losing an instruction. Flush inserts a configurable NOP bubble. An optional 2-entry skid buffer keeps `in_ready` a pure register output.

## Interface
Parameters:
- `PC_W`, 32, PC width in bits
- `INSTR_W`, 32, instruction width in bits
- `NOP_INSTR`, 32'h0000_0013, instruction word driven during a bubble (RV32 `addi x0,x0,0`); truncated or zero-extended to `INSTR_W`

Ports:
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `flush` input 1: discard all held and incoming instructions this cycle
- `in_valid` input 1: fetch presents `pc_in`/`instruction_in`
- `in_ready` output 1: stage can accept; a transfer occurs when `in_valid && in_ready`
- `pc_in` input PC_W: fetch PC
- `instruction_in` input INSTR_W: fetched instruction
- `out_valid` output 1: decode-side data valid
- `out_ready` input 1: decode consumes; a transfer occurs when `out_valid && out_ready`
- `pc_out` output PC_W: PC to decode
- `instruction_out` output INSTR_W: instruction to decode; `NOP_INSTR` whenever `out_valid`=0
- `bubble` output 1: high when the current output is a flush-generated NOP

## Operation
- Reset (`rst`=1 at an edge): `out_valid`=0, `pc_out`=0, `instruction_out`=`NOP_INSTR`, `bubble`=0, skid empty, `in_ready`=1 on the next cycle. Reset overrides `flush` and any handshake.
- Priority per edge: `rst` > `flush` > handshake.
- Flush: `out_valid`←0, skid cleared, `instruction_out`←`NOP_INSTR`, `pc_out`←`pc_in` (PC kept for debug and trace), `bubble`←1. An input presented in the flush cycle is dropped, even if `in_valid && in_ready`.
- `bubble` clears on the first accepted input after the flush.
- Main register: load on an input transfer when main is empty or is being consumed in the same cycle. Otherwise hold; outputs stay stable while `out_valid && !out_ready`.
- States (skid build): EMPTY (main invalid), FULL (main valid, skid empty), SKID (both valid).
  - EMPTY → FULL on input transfer.
  - FULL → SKID on input transfer with `!out_ready`.
  - FULL → EMPTY on output transfer with no input.
  - SKID → FULL on output transfer; main ← skid, and no input is accepted because `in_ready`=0.
  - Any state → EMPTY on flush.
- Simultaneous input and output transfer in FULL: main ← new input, state stays FULL.
- No arithmetic; widths pass straight through. No data is ever duplicated or reordered.

## Timing
- Latency: an input accepted at edge N appears on `pc_out`/`instruction_out` with `out_valid`=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Skid build: `in_ready` = !(state==SKID), registered. It deasserts the cycle after the second beat is captured and reasserts the cycle after the first SKID output transfer.
- Non-skid build: `in_ready` = `!out_valid || out_ready`, combinational.
- Flush takes effect at the edge where it is sampled; `out_valid`=0 in the following cycle.
- All outputs are registered except `in_ready` in the non-skid build.

## Configuration
- `IF_ID_SKID_EN` defined: 2-entry skid buffer, registered `in_ready`, states EMPTY/FULL/SKID.
- `IF_ID_SKID_EN` undefined: single register, combinational `in_ready`, states EMPTY/FULL only. Handshake semantics, flush and reset behaviour are identical in both builds.

## Structure
- Shared package `pipe_pkg`: `NOP_INSTR_RV32` constant and the state enum `stage_state_t` {EMPTY, FULL, SKID}, reused by the ID/EX and EX/MEM successors.
- One sub-module, `pipe_skid_buf`: the generic data-width skid entry, instantiated only under `IF_ID_SKID_EN`.

## Test plan
- Reset: hold `rst`=1 with `in_valid`=1 → `out_valid`=0, `pc_out`=0, `instruction_out`=0x13, `in_ready`=1 after release.
- Streaming: `out_ready`=1, push PC 0x0,0x4,0x8 with instr 0xA,0xB,0xC → same values out on consecutive cycles, 1-cycle latency.
- Backpressure: push 0x0/0xA then 0x4/0xB with `out_ready`=0 → output holds 0x0/0xA. Skid build: `in_ready`=0 next cycle; raising `out_ready` yields 0xA then 0xB, no loss.
- Flush in SKID: flush with 2 held entries and `in_valid`=1, `pc_in`=0x40 → next cycle `out_valid`=0, `instruction_out`=0x13, `pc_out`=0x40, `bubble`=1; input 0x40 not delivered.
- Flush plus reset in the same cycle → reset values, `bubble`=0.
- Simultaneous transfer in FULL: hold 0x8/0xC, `out_ready`=1, push 0xC/0xD → next output 0xC/0xD, state FULL.
